// File: rtl/arty_parrot_pkg.sv
// Shared types and AXI constants for the Arty bring-up memory responder.
package arty_parrot_pkg;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_wdata = 2'd1,
    e_wresp = 2'd2,
    e_read  = 2'd3
  } arty_axi_mem_state_e;

  localparam logic [1:0] axi_resp_okay_gp   = 2'b00;
  localparam logic [1:0] axi_resp_slverr_gp = 2'b10;
  localparam logic [1:0] axi_burst_incr_gp  = 2'b01;
  localparam logic [2:0] axi_size_64b_gp    = 3'd3;

endpackage

// File: rtl/arty_axi_mem_responder_if.sv
// AXI4 full-burst bus between bsg_cache_to_axi (master) and the memory responder (slave).
interface arty_axi_mem_responder_if #(
  parameter int unsigned id_width_p   = 4,
  parameter int unsigned addr_width_p = 28,
  parameter int unsigned data_width_p = 64
);
  localparam int unsigned strb_width_lp = data_width_p / 8;

  logic [id_width_p-1:0]    awid;
  logic [addr_width_p-1:0]  awaddr;
  logic [7:0]               awlen;
  logic [2:0]               awsize;
  logic [1:0]               awburst;
  logic                     awvalid;
  logic                     awready;

  logic [data_width_p-1:0]  wdata;
  logic [strb_width_lp-1:0] wstrb;
  logic                     wlast;
  logic                     wvalid;
  logic                     wready;

  logic [id_width_p-1:0]    bid;
  logic [1:0]               bresp;
  logic                     bvalid;
  logic                     bready;

  logic [id_width_p-1:0]    arid;
  logic [addr_width_p-1:0]  araddr;
  logic [7:0]               arlen;
  logic [2:0]               arsize;
  logic [1:0]               arburst;
  logic                     arvalid;
  logic                     arready;

  logic [id_width_p-1:0]    rid;
  logic [data_width_p-1:0]  rdata;
  logic [1:0]               rresp;
  logic                     rlast;
  logic                     rvalid;
  logic                     rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port RAM with byte-masked writes and a one-cycle registered read port.
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter  int unsigned els_p         = 16384,
  parameter  int unsigned data_width_p  = 64,
  localparam int unsigned addr_width_lp = $clog2(els_p),
  localparam int unsigned mask_width_lp = data_width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [data_width_p-1:0]  data_i,
  input  logic [mask_width_lp-1:0] write_mask_i,
  output logic [data_width_p-1:0]  data_o
);

  logic [data_width_p-1:0] mem [els_p];

  // Output register only loads on a read, so data_o holds between reads.
  always_ff @(posedge clk_i) begin
    if (v_i & w_i) begin
      for (int i = 0; i < int'(mask_width_lp); i++) begin
        if (write_mask_i[i]) mem[addr_i][i*8 +: 8] <= data_i[i*8 +: 8];
      end
    end
    if (v_i & ~w_i) data_o <= mem[addr_i];
  end

endmodule

// File: rtl/arty_axi_mem_responder.sv
// Block-RAM AXI4 slave standing in for the DDR3 controller; one burst at a time.
// Define ARTY_AXI_MEM_ERR_CHECK_EN to flag bad size/burst/wlast bursts with SLVERR.
module arty_axi_mem_responder
  import arty_parrot_pkg::*;
#(
  parameter int unsigned els_p            = 16384,
  parameter int unsigned axi_id_width_p   = 4,
  parameter int unsigned axi_addr_width_p = 28,
  parameter int unsigned axi_data_width_p = 64
) (
  input logic                      clk_i,
  input logic                      reset_i,
  arty_axi_mem_responder_if.slave  s_axi
);

  localparam int unsigned lg_els_lp    = $clog2(els_p);
  localparam int unsigned cnt_width_lp = 9;

  arty_axi_mem_state_e       state;
  logic                      last_grant_write;
  logic [lg_els_lp-1:0]      idx;
  logic [cnt_width_lp-1:0]   cnt;
  logic                      burst_err;
  logic                      wlast_err;

  logic [axi_addr_width_p-1:0] aw_addr_c, ar_addr_c;
  logic [axi_data_width_p-1:0] ram_data;
  logic aw_hs_c, ar_hs_c, w_hs_c, pick_ar_c;
  logic rd_en_c, wr_en_c;
  logic aw_err_c, ar_err_c, wlast_bad_c;

  assign aw_addr_c = s_axi.awaddr;
  assign ar_addr_c = s_axi.araddr;

  // Bits of the bus this responder does not interpret.
  logic unused_sideband;
  assign unused_sideband = ^{aw_addr_c[axi_addr_width_p-1:lg_els_lp+3], aw_addr_c[2:0],
                             ar_addr_c[axi_addr_width_p-1:lg_els_lp+3], ar_addr_c[2:0],
                             s_axi.awsize, s_axi.awburst, s_axi.arsize, s_axi.arburst,
                             s_axi.wlast};

`ifdef ARTY_AXI_MEM_ERR_CHECK_EN
  assign aw_err_c    = (s_axi.awsize != axi_size_64b_gp) | (s_axi.awburst != axi_burst_incr_gp);
  assign ar_err_c    = (s_axi.arsize != axi_size_64b_gp) | (s_axi.arburst != axi_burst_incr_gp);
  assign wlast_bad_c = s_axi.wlast != (cnt == cnt_width_lp'(1));
`else
  assign aw_err_c    = 1'b0;
  assign ar_err_c    = 1'b0;
  assign wlast_bad_c = 1'b0;
`endif

  // Handshakes, arbitration choice and RAM strobes.
  always_comb begin
    aw_hs_c   = s_axi.awvalid & s_axi.awready;
    ar_hs_c   = s_axi.arvalid & s_axi.arready;
    w_hs_c    = s_axi.wvalid & s_axi.wready;
    pick_ar_c = s_axi.arvalid & (~s_axi.awvalid | last_grant_write);
    rd_en_c   = (state == e_read) & (cnt != '0) & (~s_axi.rvalid | s_axi.rready);
    wr_en_c   = w_hs_c & ~burst_err;
  end

  // FSM with registered bus outputs; readies for the next idle cycle are chosen on entry.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state            <= e_idle;
      last_grant_write <= 1'b0;
      idx              <= '0;
      cnt              <= '0;
      burst_err        <= 1'b0;
      wlast_err        <= 1'b0;
      s_axi.awready    <= 1'b0;
      s_axi.arready    <= 1'b0;
      s_axi.wready     <= 1'b0;
      s_axi.bvalid     <= 1'b0;
      s_axi.bid        <= '0;
      s_axi.bresp      <= axi_resp_okay_gp;
      s_axi.rvalid     <= 1'b0;
      s_axi.rid        <= '0;
      s_axi.rresp      <= axi_resp_okay_gp;
      s_axi.rlast      <= 1'b0;
    end else begin
      case (state)
        e_idle: begin
          if (aw_hs_c) begin
            state            <= e_wdata;
            last_grant_write <= 1'b1;
            s_axi.awready    <= 1'b0;
            s_axi.arready    <= 1'b0;
            s_axi.wready     <= 1'b1;
            s_axi.bid        <= s_axi.awid;
            idx              <= aw_addr_c[3 +: lg_els_lp];
            cnt              <= cnt_width_lp'(s_axi.awlen) + cnt_width_lp'(1);
            burst_err        <= aw_err_c;
            wlast_err        <= 1'b0;
          end else if (ar_hs_c) begin
            state            <= e_read;
            last_grant_write <= 1'b0;
            s_axi.awready    <= 1'b0;
            s_axi.arready    <= 1'b0;
            s_axi.rid        <= s_axi.arid;
            idx              <= ar_addr_c[3 +: lg_els_lp];
            cnt              <= cnt_width_lp'(s_axi.arlen) + cnt_width_lp'(1);
            burst_err        <= ar_err_c;
          end else begin
            s_axi.arready <= pick_ar_c;
            s_axi.awready <= ~pick_ar_c;
          end
        end
        e_wdata: begin
          if (w_hs_c) begin
            idx <= idx + lg_els_lp'(1);
            cnt <= cnt - cnt_width_lp'(1);
            if (wlast_bad_c) wlast_err <= 1'b1;
            // The beat counter, not wlast, closes the burst.
            if (cnt == cnt_width_lp'(1)) begin
              state        <= e_wresp;
              s_axi.wready <= 1'b0;
              s_axi.bvalid <= 1'b1;
              s_axi.bresp  <= (burst_err | wlast_err | wlast_bad_c) ? axi_resp_slverr_gp
                                                                    : axi_resp_okay_gp;
            end
          end
        end
        e_wresp: begin
          if (s_axi.bready) begin
            state         <= e_idle;
            s_axi.bvalid  <= 1'b0;
            s_axi.arready <= pick_ar_c;
            s_axi.awready <= ~pick_ar_c;
          end
        end
        e_read: begin
          if (rd_en_c) begin
            idx          <= idx + lg_els_lp'(1);
            cnt          <= cnt - cnt_width_lp'(1);
            s_axi.rvalid <= 1'b1;
            s_axi.rlast  <= (cnt == cnt_width_lp'(1));
            s_axi.rresp  <= burst_err ? axi_resp_slverr_gp : axi_resp_okay_gp;
          end else if (s_axi.rvalid & s_axi.rready) begin
            s_axi.rvalid <= 1'b0;
            s_axi.rlast  <= 1'b0;
            if (s_axi.rlast) begin
              state         <= e_idle;
              s_axi.arready <= pick_ar_c;
              s_axi.awready <= ~pick_ar_c;
            end
          end
        end
        default: state <= e_idle;
      endcase
    end
  end

  bsg_mem_1rw_sync_mask_write_byte #(
    .els_p        (els_p),
    .data_width_p (axi_data_width_p)
  ) mem (
    .clk_i        (clk_i),
    .v_i          (wr_en_c | rd_en_c),
    .w_i          (wr_en_c),
    .addr_i       (idx),
    .data_i       (s_axi.wdata),
    .write_mask_i (s_axi.wstrb),
    .data_o       (ram_data)
  );

  assign s_axi.rdata = ram_data;

endmodule

// File: tb/tb_arty_axi_mem_responder.sv
// Scoreboard bench for arty_axi_mem_responder: expected B/R responses queued at issue, checked at handshake.
module tb_arty_axi_mem_responder;
  import arty_parrot_pkg::*;

  localparam int unsigned els_lp = 16384;
`ifdef ARTY_AXI_MEM_ERR_CHECK_EN
  localparam bit err_en_lp = 1'b1;
`else
  localparam bit err_en_lp = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  id;
    logic        last;
    logic [1:0]  resp;
  } r_exp_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  logic clk;
  logic reset_i;
  int unsigned n_cmp;
  int unsigned n_err;

  r_exp_t rq[$];
  b_exp_t bq[$];
  logic [63:0] wq[$];
  logic [63:0] model [int unsigned];

  r_exp_t held, re;
  b_exp_t be;
  bit     held_v;

  arty_axi_mem_responder_if #(.id_width_p(4), .addr_width_p(28), .data_width_p(64)) bus ();

  arty_axi_mem_responder #(
    .els_p(els_lp), .axi_id_width_p(4), .axi_addr_width_p(28), .axi_data_width_p(64)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .s_axi   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] strb);
    logic [63:0] r = old;
    for (int i = 0; i < 8; i++) if (strb[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  function automatic int unsigned word_of(input logic [27:0] addr, input int unsigned beat);
    return ((int'(addr) >> 3) + beat) % els_lp;
  endfunction

  // Response monitor: pops the scoreboard on handshakes and checks stalled beats stay put.
  always @(negedge clk) begin
    if (reset_i) begin
      held_v = 1'b0;
    end else begin
      if (bus.bvalid && bus.bready) begin
        if (bq.size() == 0) check("b_unexpected", 1, 0);
        else begin
          be = bq.pop_front();
          check("bid", bus.bid, be.id);
          check("bresp", bus.bresp, be.resp);
        end
      end
      if (bus.rvalid) begin
        if (held_v) begin
          check("r_hold_data", bus.rdata, held.data);
          check("r_hold_last", bus.rlast, held.last);
          check("r_hold_id", bus.rid, held.id);
        end
        if (bus.rready) begin
          held_v = 1'b0;
          if (rq.size() == 0) check("r_unexpected", 1, 0);
          else begin
            re = rq.pop_front();
            check("rdata", bus.rdata, re.data);
            check("rid", bus.rid, re.id);
            check("rlast", bus.rlast, re.last);
            check("rresp", bus.rresp, re.resp);
          end
        end else begin
          held_v    = 1'b1;
          held.data = bus.rdata;
          held.id   = bus.rid;
          held.last = bus.rlast;
          held.resp = bus.rresp;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    tick();
    check("rst_awready", bus.awready, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_resp", {bus.bresp, bus.rresp, bus.rlast}, 0);
    check("rst_ids", {bus.bid, bus.rid}, 0);
    reset_i = 1'b0;
    tick();
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [27:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit got = 1'b0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.awready) got = 1'b1;
    end
    tick();
    bus.awvalid = 1'b0;
    if (!got) check("aw_timeout", 0, 1);
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [27:0] addr, input logic [7:0] len,
                         input logic [2:0] size);
    bit got = 1'b0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size;
    bus.arburst = axi_burst_incr_gp;
    bus.arvalid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.arready) got = 1'b1;
    end
    tick();
    bus.arvalid = 1'b0;
    if (!got) check("ar_timeout", 0, 1);
  endtask

  task automatic send_w(input logic [7:0] strb);
    bit got;
    for (int b = 0; b < wq.size(); b++) begin
      bus.wdata = wq[b]; bus.wstrb = strb; bus.wlast = (b == wq.size() - 1);
      bus.wvalid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        @(negedge clk);
        if (bus.wready) got = 1'b1;
      end
      tick();
      if (!got) check("w_timeout", 0, 1);
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
  endtask

  // Writes wq as one burst; model updated only when the burst is not an errored one.
  task automatic write_burst(input logic [3:0] id, input logic [27:0] addr, input logic [7:0] strb,
                             input logic [1:0] burst);
    bit err = err_en_lp && (burst != axi_burst_incr_gp);
    int unsigned w;
    bq.push_back('{id: id, resp: err ? axi_resp_slverr_gp : axi_resp_okay_gp});
    send_aw(id, addr, 8'(wq.size() - 1), 3'd3, burst);
    send_w(strb);
    if (!err) begin
      for (int b = 0; b < wq.size(); b++) begin
        w = word_of(addr, b);
        model[w] = merge(model.exists(w) ? model[w] : 64'h0, wq[b], strb);
      end
    end
    for (int i = 0; i < 200 && bq.size() != 0; i++) tick();
    if (bq.size() != 0) begin
      check("b_timeout", bq.size(), 0);
      bq.delete();
    end
  endtask

  task automatic push_reads(input logic [3:0] id, input logic [27:0] addr, input logic [7:0] len,
                            input logic [2:0] size);
    bit err = err_en_lp && (size != 3'd3);
    for (int b = 0; b <= int'(len); b++)
      rq.push_back('{data: model[word_of(addr, b)], id: id, last: (b == int'(len)),
                     resp: err ? axi_resp_slverr_gp : axi_resp_okay_gp});
  endtask

  // mode 0: rready held high; mode 1: rready pattern 1,0,0,1,0,0...
  task automatic drain(input int mode);
    for (int c = 0; c < 400 && rq.size() != 0; c++) begin
      bus.rready = (mode == 0) ? 1'b1 : (c % 3 == 0);
      tick();
    end
    bus.rready = 1'b1;
    if (rq.size() != 0) begin
      check("r_timeout", rq.size(), 0);
      rq.delete();
    end
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [27:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input int mode);
    push_reads(id, addr, len, size);
    send_ar(id, addr, len, size);
    drain(mode);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; held_v = 1'b0;
    reset_i = 1'b1;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd3; bus.awburst = 2'b01;
    bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd3; bus.arburst = 2'b01;
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    do_reset();
    check("idle_awready", bus.awready, 1);

    // Write then read a 4-beat burst.
    wq = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
    write_burst(4'd3, 28'h100, 8'hFF, axi_burst_incr_gp);
    read_burst(4'd6, 28'h100, 8'd3, 3'd3, 0);

    // Partial strobe over a full-ones word.
    wq = '{64'hFFFF_FFFF_FFFF_FFFF};
    write_burst(4'd1, 28'h100, 8'hFF, axi_burst_incr_gp);
    wq = '{64'h1122};
    write_burst(4'd1, 28'h100, 8'h03, axi_burst_incr_gp);
    read_burst(4'd2, 28'h100, 8'd0, 3'd3, 0);

    // Backpressure on a 4-beat read of random data.
    wq = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
    write_burst(4'd4, 28'h400, 8'hFF, axi_burst_incr_gp);
    read_burst(4'd4, 28'h400, 8'd3, 3'd3, 1);
    check("bp_idle", 64'(dut.state), 64'(e_idle));

    // Index wrap past the top word.
    wq = '{64'h1111, 64'h2222};
    write_burst(4'd7, 28'((els_lp - 1) * 8), 8'hFF, axi_burst_incr_gp);
    read_burst(4'd8, 28'h0, 8'd0, 3'd3, 0);
    read_burst(4'd8, 28'((els_lp - 1) * 8), 8'd1, 3'd3, 0);

    // Size / burst-type errors (SLVERR and suppressed write only when checking is built in).
    read_burst(4'd9, 28'h100, 8'd3, 3'd2, 0);
    wq = '{64'hDEAD};
    write_burst(4'd10, 28'h100, 8'hFF, 2'b00);
    read_burst(4'd11, 28'h100, 8'd0, 3'd3, 0);

    // Simultaneous AW/AR right after reset: write first, read on the next idle cycle.
    do_reset();
    bq.push_back('{id: 4'd5, resp: axi_resp_okay_gp});
    model[word_of(28'h200, 0)] = 64'h55;
    push_reads(4'd9, 28'h100, 8'd0, 3'd3);
    bus.awid = 4'd5; bus.awaddr = 28'h200; bus.awlen = 8'd0; bus.awsize = 3'd3;
    bus.awburst = axi_burst_incr_gp; bus.awvalid = 1'b1;
    bus.arid = 4'd9; bus.araddr = 28'h100; bus.arlen = 8'd0; bus.arsize = 3'd3;
    bus.arburst = axi_burst_incr_gp; bus.arvalid = 1'b1;
    @(negedge clk);
    check("sim_awready_first", bus.awready, 1);
    check("sim_arready_first", bus.arready, 0);
    tick();
    bus.awvalid = 1'b0;
    wq = '{64'h55};
    send_w(8'hFF);
    for (int i = 0; i < 200 && bq.size() != 0; i++) tick();
    check("sim_b_done", bq.size(), 0);
    check("sim_arready_next", bus.arready, 1);
    check("sim_awready_next", bus.awready, 0);
    tick();
    bus.arvalid = 1'b0;
    drain(0);
    read_burst(4'd12, 28'h200, 8'd0, 3'd3, 0);

    // Reset after the first beat of an 8-beat read; array survives.
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back({$urandom, $urandom});
    write_burst(4'd2, 28'h800, 8'hFF, axi_burst_incr_gp);
    push_reads(4'd3, 28'h800, 8'd7, 3'd3);
    send_ar(4'd3, 28'h800, 8'd7, 3'd3);
    for (int c = 0; c < 100 && rq.size() > 7; c++) tick();
    check("rst_mid_beat1", rq.size(), 7);
    reset_i = 1'b1;
    bus.rready = 1'b0;
    tick();
    check("rst_mid_rvalid", bus.rvalid, 0);
    reset_i = 1'b0;
    rq.delete();
    bus.rready = 1'b1;
    tick();
    check("rst_mid_awready", bus.awready, 1);
    check("rst_mid_arready", bus.arready, 0);
    read_burst(4'd4, 28'h800, 8'd7, 3'd3, 0);
    read_burst(4'd5, 28'h100, 8'd0, 3'd3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
